// File: rtl/zpc_pkg.sv
// Shared ZPC pipeline definitions: instruction field positions, fetch FSM states, fetch word record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Reused by the fetch stage, the decode stage and the controller.
package zpc_pkg;

    // Default first fetch address after reset
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // MIPS instruction field bit positions
    localparam int OP_HI    = 31;
    localparam int OP_LO    = 26;
    localparam int RS_HI    = 25;
    localparam int RS_LO    = 21;
    localparam int RT_HI    = 20;
    localparam int RT_LO    = 16;
    localparam int RD_HI    = 15;
    localparam int RD_LO    = 11;
    localparam int SHAMT_HI = 10;
    localparam int SHAMT_LO = 6;
    localparam int FUNC_HI  = 5;
    localparam int FUNC_LO  = 0;
    localparam int IMME_HI  = 15;
    localparam int IMME_LO  = 0;

    // Fetch FSM: IDLE = no request, REQ = response kept, KILL = response discarded
    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_REQ  = 2'd1,
        FS_KILL = 2'd2
    } fetch_state_t;

    // One fetched instruction together with its link pc (fetch address + 4)
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_t;

endpackage

// File: rtl/if_skid.sv
// One-entry skid buffer holding a fetched {pc+4, instr} while decode is stalled.
// Latency: load visible on dout/vld the cycle after the load edge.
// Backpressure: none internally; the fetch FSM stops requesting while vld is high.
// Ports: clk, rst (async, active-high); load/unload/flush controls; din in; vld, dout out.
module if_skid
    import zpc_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   load,
    input  logic   unload,
    input  logic   flush,
    input  fetch_t din,
    output logic   vld,
    output fetch_t dout
);

    // flush wins; a simultaneous load+unload keeps the entry full with the new word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld  <= 1'b0;
            dout <= '0;
        end else begin
            if (flush) begin
                vld <= 1'b0;
            end else if (load) begin
                vld <= 1'b1;
            end else if (unload) begin
                vld <= 1'b0;
            end
            if (load && !flush) begin
                dout <= din;
            end
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the pc, handshakes with imem, registers decoded fields for decode.
// Latency: imem_ack in cycle N gives ifid_valid in cycle N+1; zero-wait memory sustains 1 instr/cycle.
// Backpressure: id_stall holds the output register; one extra word parks in the skid, then imem_req drops.
// Ports: clk, rst (async, active-high); imem_req/imem_addr/imem_ack/imem_rdata memory side;
//        id_stall, redirect/redirect_pc from later stages; ifid_* registered decode fields.
module if_stage
    import zpc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        id_stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        ifid_valid,
    output logic [31:0] ifid_pc,
    output logic [5:0]  ifid_op,
    output logic [4:0]  ifid_rs,
    output logic [4:0]  ifid_rt,
    output logic [4:0]  ifid_rd,
    output logic [4:0]  ifid_shamt,
    output logic [5:0]  ifid_func,
    output logic [15:0] ifid_imme
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  redir_pc;
    fetch_t       ifid_dat;
    fetch_t       ack_dat;
    fetch_t       skid_dat;
    logic         skid_vld;
    logic         ack_take;
    logic         out_open;
    logic         ack_to_out;
    logic         ack_to_skid;
    logic         skid_unload;
    logic         skid_empty_next;

    assign imem_addr = pc;
    assign redir_pc  = redirect_pc & ~32'h3;
    assign ack_dat   = {pc + 32'd4, imem_rdata};

    // Only a REQ-state ack without a concurrent redirect delivers a usable word
    assign ack_take        = (state == FS_REQ) && imem_ack && !redirect;
    assign out_open        = !ifid_valid || !id_stall;
    assign ack_to_out      = ack_take && out_open && !skid_vld;
    assign ack_to_skid     = ack_take && !ack_to_out;
    assign skid_unload     = out_open && skid_vld && !redirect;
    assign skid_empty_next = !ack_to_skid && (!skid_vld || skid_unload);

    if_skid u_skid (
        .clk    (clk),
        .rst    (rst),
        .load   (ack_to_skid),
        .unload (skid_unload),
        .flush  (redirect),
        .din    (ack_dat),
        .vld    (skid_vld),
        .dout   (skid_dat)
    );

    // Fetch FSM; imem_req is registered and mirrors state != IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= FS_IDLE;
            pc       <= RESET_PC;
            imem_req <= 1'b0;
        end else if (redirect) begin
            pc       <= redir_pc;
            imem_req <= 1'b1;
            // an outstanding request with no ack yet still owes a response that must be eaten
            if ((state != FS_IDLE) && !imem_ack) begin
                state <= FS_KILL;
            end else begin
                state <= FS_REQ;
            end
        end else begin
            case (state)
                FS_KILL: begin
                    if (imem_ack) begin
                        state <= FS_REQ;
                    end
                end
                FS_REQ: begin
                    if (imem_ack) begin
                        pc <= pc + 32'd4;
                        if (skid_empty_next) begin
                            state <= FS_REQ;
                        end else begin
                            state    <= FS_IDLE;
                            imem_req <= 1'b0;
                        end
                    end
                end
                default: begin
                    if (!skid_vld) begin
                        state    <= FS_REQ;
                        imem_req <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Output register: skid has priority over fresh ack data to keep program order
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ifid_valid <= 1'b0;
            ifid_dat   <= '0;
        end else if (redirect) begin
            ifid_valid <= 1'b0;
        end else if (out_open) begin
            if (skid_vld) begin
                ifid_valid <= 1'b1;
                ifid_dat   <= skid_dat;
            end else if (ack_to_out) begin
                ifid_valid <= 1'b1;
                ifid_dat   <= ack_dat;
            end else begin
                ifid_valid <= 1'b0;
            end
        end
    end

    assign ifid_pc    = ifid_dat.pc;
    assign ifid_op    = ifid_dat.instr[OP_HI:OP_LO];
    assign ifid_rs    = ifid_dat.instr[RS_HI:RS_LO];
    assign ifid_rt    = ifid_dat.instr[RT_HI:RT_LO];
    assign ifid_rd    = ifid_dat.instr[RD_HI:RD_LO];
    assign ifid_shamt = ifid_dat.instr[SHAMT_HI:SHAMT_LO];
    assign ifid_func  = ifid_dat.instr[FUNC_HI:FUNC_LO];
    assign ifid_imme  = ifid_dat.instr[IMME_HI:IMME_LO];

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: memory model with programmable latency, scoreboard of expected fetches.
// Latency: n/a.
// Backpressure: drives id_stall and redirect directly from the stimulus sequence.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        id_stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        ifid_valid;
    logic [31:0] ifid_pc;
    logic [5:0]  ifid_op;
    logic [4:0]  ifid_rs;
    logic [4:0]  ifid_rt;
    logic [4:0]  ifid_rd;
    logic [4:0]  ifid_shamt;
    logic [5:0]  ifid_func;
    logic [15:0] ifid_imme;

    if_stage #(.RESET_PC(32'h0000_0100)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .id_stall    (id_stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .ifid_valid  (ifid_valid),
        .ifid_pc     (ifid_pc),
        .ifid_op     (ifid_op),
        .ifid_rs     (ifid_rs),
        .ifid_rt     (ifid_rt),
        .ifid_rd     (ifid_rd),
        .ifid_shamt  (ifid_shamt),
        .ifid_func   (ifid_func),
        .ifid_imme   (ifid_imme)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   lat    = 0;
    int   wcnt   = 0;
    bit   kill_pend = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 32'h8C22_0004;
            32'h0000_0104: return 32'h0043_0820;
            default:       return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
        endcase
    endfunction

    // One clock: consume/check at the output, answer memory, then advance to next negedge.
    task automatic tick();
        exp_t e;
        if (ifid_valid && !id_stall) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected", {31'd0, ifid_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("sb_pc",    ifid_pc,    e.pc);
                chk("sb_op",    {26'd0, ifid_op},    {26'd0, e.instr[31:26]});
                chk("sb_rs",    {27'd0, ifid_rs},    {27'd0, e.instr[25:21]});
                chk("sb_rt",    {27'd0, ifid_rt},    {27'd0, e.instr[20:16]});
                chk("sb_rd",    {27'd0, ifid_rd},    {27'd0, e.instr[15:11]});
                chk("sb_shamt", {27'd0, ifid_shamt}, {27'd0, e.instr[10:6]});
                chk("sb_func",  {26'd0, ifid_func},  {26'd0, e.instr[5:0]});
                chk("sb_imme",  {16'd0, ifid_imme},  {16'd0, e.instr[15:0]});
            end
        end
        if (redirect) sb.delete();
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        if (imem_req) begin
            if (wcnt >= lat) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(imem_addr);
                if (!(redirect || kill_pend)) begin
                    e.pc    = imem_addr + 32'd4;
                    e.instr = imem_rdata;
                    sb.push_back(e);
                end
                kill_pend = 1'b0;
                wcnt      = 0;
            end else begin
                wcnt++;
                if (redirect) kill_pend = 1'b1;
            end
        end else begin
            wcnt = 0;
        end
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        id_stall    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_req",    {31'd0, imem_req},   32'd0);
        chk("rst_addr",   imem_addr,           32'h100);
        chk("rst_valid",  {31'd0, ifid_valid}, 32'd0);
        chk("rst_pc",     ifid_pc,             32'd0);
        chk("rst_fields", {ifid_op, ifid_rs, ifid_rt, ifid_rd, ifid_shamt, ifid_func}, 32'd0);
        chk("rst_imme",   {16'd0, ifid_imme},  32'd0);

        rst = 1'b0;
        @(negedge clk);
        chk("first_req",  {31'd0, imem_req}, 32'd1);
        chk("first_addr", imem_addr,         32'h100);

        // Zero-wait stream from 0x100
        lat = 0;
        tick();
        chk("zw_valid0", {31'd0, ifid_valid}, 32'd1);
        chk("zw_pc0",    ifid_pc,             32'h104);
        tick();
        chk("zw_valid1", {31'd0, ifid_valid}, 32'd1);
        chk("zw_pc1",    ifid_pc,             32'h108);
        chk("zw_op",     {26'd0, ifid_op},    32'd0);
        chk("zw_rs",     {27'd0, ifid_rs},    32'd2);
        chk("zw_rt",     {27'd0, ifid_rt},    32'd3);
        chk("zw_rd",     {27'd0, ifid_rd},    32'd1);
        chk("zw_shamt",  {27'd0, ifid_shamt}, 32'd0);
        chk("zw_func",   {26'd0, ifid_func},  32'h20);
        chk("zw_imme",   {16'd0, ifid_imme},  32'h0820);
        repeat (4) tick();

        // Three-cycle memory latency
        lat = 2;
        for (int k = 0; k < 9; k++) begin
            chk("lat_req",   {31'd0, imem_req},   32'd1);
            chk("lat_addr",  imem_addr,           32'h118 + 32'(4 * (k / 3)));
            chk("lat_valid", {31'd0, ifid_valid}, (k % 3 == 0) ? 32'd1 : 32'd0);
            tick();
        end

        // Decode stall for four cycles, zero-wait memory
        lat      = 0;
        id_stall = 1'b1;
        tick();
        for (int i = 1; i < 4; i++) begin
            chk("stall_req",   {31'd0, imem_req},   32'd0);
            chk("stall_valid", {31'd0, ifid_valid}, 32'd1);
            chk("stall_pc",    ifid_pc,             32'h124);
            tick();
        end
        id_stall = 1'b0;
        chk("rel_pc0", ifid_pc, 32'h124);
        tick();
        chk("rel_valid1", {31'd0, ifid_valid}, 32'd1);
        chk("rel_pc1",    ifid_pc,             32'h128);
        tick();
        chk("rel_req",  {31'd0, imem_req}, 32'd1);
        chk("rel_addr", imem_addr,         32'h128);
        repeat (3) tick();

        // Redirect while a request is outstanding; ack arrives two cycles later
        lat = 2;
        for (int i = 0; i < 20 && !(imem_req && wcnt == 0); i++) tick();
        chk("kill_sync", {31'd0, imem_req}, 32'd1);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_2003;
        tick();
        redirect = 1'b0;
        chk("kill_valid0", {31'd0, ifid_valid}, 32'd0);
        chk("kill_req",    {31'd0, imem_req},   32'd1);
        tick();
        chk("kill_valid1", {31'd0, ifid_valid}, 32'd0);
        tick();
        chk("kill_valid2", {31'd0, ifid_valid}, 32'd0);
        chk("kill_addr",   imem_addr,           32'h2000);
        chk("kill_req2",   {31'd0, imem_req},   32'd1);
        repeat (3) tick();
        chk("kill_valid3", {31'd0, ifid_valid}, 32'd1);
        chk("kill_pc",     ifid_pc,             32'h2004);

        // Redirect while stalled with the skid full
        lat      = 0;
        id_stall = 1'b1;
        for (int i = 0; i < 10 && imem_req; i++) tick();
        chk("sf_req",   {31'd0, imem_req},   32'd0);
        chk("sf_valid", {31'd0, ifid_valid}, 32'd1);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_3000;
        tick();
        redirect = 1'b0;
        chk("sf_valid_after", {31'd0, ifid_valid}, 32'd0);
        chk("sf_req_after",   {31'd0, imem_req},   32'd1);
        chk("sf_addr_after",  imem_addr,           32'h3000);
        tick();

        // Redirect in the same cycle as an ack, still stalled
        chk("ra_valid", {31'd0, ifid_valid}, 32'd1);
        chk("ra_pc",    ifid_pc,             32'h3004);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_4000;
        tick();
        redirect = 1'b0;
        chk("ra_valid_after", {31'd0, ifid_valid}, 32'd0);
        chk("ra_req_after",   {31'd0, imem_req},   32'd1);
        chk("ra_addr_after",  imem_addr,           32'h4000);
        id_stall = 1'b0;
        tick();
        chk("ra_valid_next", {31'd0, ifid_valid}, 32'd1);
        chk("ra_pc_next",    ifid_pc,             32'h4004);
        repeat (2) tick();

        // Drain: memory stops answering, everything queued must come out
        lat = 1000;
        repeat (4) tick();
        chk("drain_sb",    32'(sb.size()),      32'd0);
        chk("drain_valid", {31'd0, ifid_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
